// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-following rover controller:
// H-bridge codes, controller states, sensor classes and pivot direction.
package line_follow_pkg;

  localparam logic [3:0] MC_FWD   = 4'b0101;
  localparam logic [3:0] MC_LEFT  = 4'b1010;
  localparam logic [3:0] MC_RIGHT = 4'b0110;
  localparam logic [3:0] MC_BRAKE = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    TURN_L = 3'd2,
    TURN_R = 3'd3,
    SEARCH = 3'd4,
    OBST   = 3'd5,
    STOP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_FWD   = 3'd0,
    CL_LEFT  = 3'd1,
    CL_RIGHT = 3'd2,
    CL_NONE  = 3'd3,
    CL_CROSS = 3'd4
  } class_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  function automatic logic [3:0] pivot_code(dir_e dir);
    return (dir == DIR_RIGHT) ? MC_RIGHT : MC_LEFT;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a per-bit debouncer: a filtered bit only
// follows its synchronised input after DEB_CYC consecutive cycles of disagreement.
module input_debounce #(
  parameter int WIDTH   = 1,
  parameter int DEB_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] filt_o
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle of agreement (a bounce back) clears the run counter.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CYC - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Rover steering controller: debounced sensors feed a priority state machine
// (halt > obstacle > line class) driving registered H-bridge code and PWM enables.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int N_SENS     = 3,
  parameter int PWM_W      = 8,
  parameter int DEB_CYC    = 16,
  parameter int LOST_CYC   = 50000,
  parameter int RESUME_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SENS-1:0] induct,
  input  logic              proxim,
  input  logic              red,
  input  logic [PWM_W-1:0]  duty_fwd,
  input  logic [PWM_W-1:0]  duty_turn,
  output logic [3:0]        motor_in,
  output logic [1:0]        motor_en,
  output logic [2:0]        state_o,
  output logic              lost
);

  localparam int CENTRE = N_SENS / 2;
  localparam int SRCH_W = (LOST_CYC > 1) ? $clog2(LOST_CYC) : 1;
  localparam int RES_W  = (RESUME_CYC > 1) ? $clog2(RESUME_CYC) : 1;

  logic [N_SENS-1:0] induct_f;
  logic [1:0]        ctl_f;
  logic              prox_f;
  logic              red_f;

  input_debounce #(
    .WIDTH   (N_SENS),
    .DEB_CYC (DEB_CYC)
  ) u_induct_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (induct),
    .filt_o (induct_f)
  );

  input_debounce #(
    .WIDTH   (2),
    .DEB_CYC (DEB_CYC)
  ) u_ctl_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  ({proxim, red}),
    .filt_o (ctl_f)
  );

  assign prox_f = ctl_f[1];
  assign red_f  = ctl_f[0];

  logic   left_any;
  logic   right_any;
  class_e cls;

  always_comb begin
    left_any  = |induct_f[CENTRE-1:0];
    right_any = |induct_f[N_SENS-1:CENTRE+1];
    if (left_any && right_any) begin
      cls = CL_CROSS;
    end else if (left_any) begin
      cls = CL_LEFT;
    end else if (right_any) begin
      cls = CL_RIGHT;
    end else if (induct_f[CENTRE]) begin
      cls = CL_FWD;
    end else begin
      cls = CL_NONE;
    end
  end

  state_e            state_q, state_d;
  state_e            saved_q, saved_d;
  dir_e              last_turn_q, last_turn_d;
  logic [SRCH_W-1:0] search_cnt_q, search_cnt_d;
  logic [RES_W-1:0]  resume_cnt_q, resume_cnt_d;

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    search_cnt_d = search_cnt_q;
    resume_cnt_d = '0;
    if (red_f) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = FOLLOW;
        FOLLOW, TURN_L, TURN_R: begin
          if (prox_f) begin
            saved_d = state_q;
            state_d = OBST;
          end else begin
            case (cls)
              CL_FWD:   state_d = FOLLOW;
              CL_LEFT:  state_d = TURN_L;
              CL_RIGHT: state_d = TURN_R;
              CL_NONE: begin
                state_d      = SEARCH;
                search_cnt_d = '0;
              end
              default: state_d = state_q;
            endcase
          end
        end
        // A crossing seen while searching does not end the search.
        SEARCH: begin
          if (prox_f) begin
            saved_d = SEARCH;
            state_d = OBST;
          end else begin
            case (cls)
              CL_FWD:   state_d = FOLLOW;
              CL_LEFT:  state_d = TURN_L;
              CL_RIGHT: state_d = TURN_R;
              default: begin
                if (search_cnt_q == SRCH_W'(LOST_CYC - 1)) begin
                  state_d = STOP;
                end else begin
                  search_cnt_d = search_cnt_q + SRCH_W'(1);
                end
              end
            endcase
          end
        end
        OBST: begin
          if (!prox_f) begin
            if (resume_cnt_q == RES_W'(RESUME_CYC - 1)) begin
              state_d = saved_q;
            end else begin
              resume_cnt_d = resume_cnt_q + RES_W'(1);
            end
          end
        end
        STOP:    state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    last_turn_d = last_turn_q;
    if (state_d == TURN_L) begin
      last_turn_d = DIR_LEFT;
    end else if (state_d == TURN_R) begin
      last_turn_d = DIR_RIGHT;
    end
  end

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_sel;
  logic             pwm_on;
  logic [3:0]       motor_in_q, motor_in_d;
  logic [1:0]       motor_en_q, motor_en_d;
  logic             lost_q, lost_d;

  // Outputs follow the next state so they line up with state_o.
  always_comb begin
    motor_in_d = MC_BRAKE;
    duty_sel   = '0;
    case (state_d)
      FOLLOW: begin
        motor_in_d = MC_FWD;
        duty_sel   = duty_fwd;
      end
      TURN_L: begin
        motor_in_d = MC_LEFT;
        duty_sel   = duty_turn;
      end
      TURN_R: begin
        motor_in_d = MC_RIGHT;
        duty_sel   = duty_turn;
      end
      SEARCH: begin
        motor_in_d = pivot_code(last_turn_d);
        duty_sel   = duty_turn;
      end
      default: begin
        motor_in_d = MC_BRAKE;
        duty_sel   = '0;
      end
    endcase
    pwm_on     = (duty_sel == '1) || (pwm_cnt_q < duty_sel);
    motor_en_d = {pwm_on, pwm_on};
    lost_d     = (state_d == STOP);
    pwm_cnt_d  = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      saved_q      <= IDLE;
      last_turn_q  <= DIR_LEFT;
      search_cnt_q <= '0;
      resume_cnt_q <= '0;
      pwm_cnt_q    <= '0;
      motor_in_q   <= MC_BRAKE;
      motor_en_q   <= 2'b00;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      last_turn_q  <= last_turn_d;
      search_cnt_q <= search_cnt_d;
      resume_cnt_q <= resume_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      motor_in_q   <= motor_in_d;
      motor_en_q   <= motor_en_d;
      lost_q       <= lost_d;
    end
  end

  assign motor_in = motor_in_q;
  assign motor_en = motor_en_q;
  assign state_o  = state_q;
  assign lost     = lost_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl: a table of held input patterns with
// fixed expected results, hand-written timing sequences, and a random phase.
module tb_line_follow_ctrl;
  import line_follow_pkg::*;

  localparam int N_SENS     = 3;
  localparam int PWM_W      = 8;
  localparam int DEB_CYC    = 4;
  localparam int LOST_CYC   = 20;
  localparam int RESUME_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] induct = 3'b000;
  logic       proxim = 1'b0;
  logic       red = 1'b0;
  logic [7:0] duty_fwd = 8'h80;
  logic [7:0] duty_turn = 8'h40;
  logic [3:0] motor_in;
  logic [1:0] motor_en;
  logic [2:0] state_o;
  logic       lost;

  int vec_cnt = 0;
  int miss_cnt = 0;

  line_follow_ctrl #(
    .N_SENS     (N_SENS),
    .PWM_W      (PWM_W),
    .DEB_CYC    (DEB_CYC),
    .LOST_CYC   (LOST_CYC),
    .RESUME_CYC (RESUME_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .induct    (induct),
    .proxim    (proxim),
    .red       (red),
    .duty_fwd  (duty_fwd),
    .duty_turn (duty_turn),
    .motor_in  (motor_in),
    .motor_en  (motor_en),
    .state_o   (state_o),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample history {proxim, red, induct}, newest last.
  logic [4:0] m_hist[$];
  logic [4:0] m_filt;
  state_e     m_state;
  state_e     m_saved;
  logic       m_dir_right;
  int         m_search_age;
  int         m_clear_streak;
  int         m_pwm;
  logic [3:0] m_exp_mi;
  logic [1:0] m_exp_en;

  task automatic modelReset();
    m_state        = IDLE;
    m_saved        = IDLE;
    m_dir_right    = 1'b0;
    m_search_age   = 0;
    m_clear_streak = 0;
    m_pwm          = 0;
    m_filt         = 5'b0;
    m_exp_mi       = 4'b0000;
    m_exp_en       = 2'b00;
    m_hist.delete();
    for (int i = 0; i < DEB_CYC + 2; i++) m_hist.push_back(5'b0);
  endtask

  // Sensor word to target state; a crossing keeps the current state.
  function automatic state_e lineTarget(logic [2:0] s, state_e cur);
    int nl = 0;
    int nr = 0;
    for (int i = 0; i < N_SENS; i++) begin
      if (i < N_SENS / 2) nl += int'(s[i]);
      if (i > N_SENS / 2) nr += int'(s[i]);
    end
    if (nl > 0 && nr > 0) return cur;
    if (nl > 0) return TURN_L;
    if (nr > 0) return TURN_R;
    if (s[N_SENS / 2]) return FOLLOW;
    return SEARCH;
  endfunction

  task automatic modelStep();
    state_e     ns;
    logic [7:0] duty;
    logic       on;
    logic       all_diff;
    ns = m_state;
    if (m_filt[3]) begin
      ns = IDLE;
    end else begin
      case (m_state)
        IDLE: ns = FOLLOW;
        FOLLOW, TURN_L, TURN_R: begin
          if (m_filt[4]) begin
            m_saved = m_state; ns = OBST; m_clear_streak = 0;
          end else begin
            ns = lineTarget(m_filt[2:0], m_state);
            if (ns == SEARCH) m_search_age = 0;
          end
        end
        SEARCH: begin
          if (m_filt[4]) begin
            m_saved = SEARCH; ns = OBST; m_clear_streak = 0;
          end else begin
            ns = lineTarget(m_filt[2:0], SEARCH);
            if (ns == SEARCH) begin
              m_search_age++;
              if (m_search_age >= LOST_CYC) ns = STOP;
            end
          end
        end
        OBST: begin
          if (m_filt[4]) begin
            m_clear_streak = 0;
          end else begin
            m_clear_streak++;
            if (m_clear_streak >= RESUME_CYC) ns = m_saved;
          end
        end
        default: ns = m_state;
      endcase
    end
    if (ns == TURN_L) m_dir_right = 1'b0;
    if (ns == TURN_R) m_dir_right = 1'b1;
    duty = 8'h00;
    m_exp_mi = 4'b0000;
    case (ns)
      FOLLOW: begin m_exp_mi = 4'b0101; duty = duty_fwd; end
      TURN_L: begin m_exp_mi = 4'b1010; duty = duty_turn; end
      TURN_R: begin m_exp_mi = 4'b0110; duty = duty_turn; end
      SEARCH: begin m_exp_mi = m_dir_right ? 4'b0110 : 4'b1010; duty = duty_turn; end
      default: ;
    endcase
    on = (duty == 8'hFF) || (m_pwm < int'(duty));
    m_exp_en = {on, on};
    m_pwm = (m_pwm + 1) % 256;
    m_state = ns;
    m_hist.push_back({proxim, red, induct});
    while (m_hist.size() > DEB_CYC + 2) void'(m_hist.pop_front());
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DEB_CYC + 1; j++) begin
        if (m_hist[$-j][b] == m_filt[b]) all_diff = 1'b0;
      end
      if (all_diff) m_filt[b] = ~m_filt[b];
    end
  endtask

  task automatic checkOutput(string tag);
    vec_cnt++;
    if (state_o !== 3'(m_state)) begin
      miss_cnt++;
      $display("[TB] FAIL %s state_o: got %0d expected %0d at %0t", tag, state_o, m_state, $time);
    end
    if (motor_in !== m_exp_mi) begin
      miss_cnt++;
      $display("[TB] FAIL %s motor_in: got %b expected %b at %0t", tag, motor_in, m_exp_mi, $time);
    end
    if (motor_en !== m_exp_en) begin
      miss_cnt++;
      $display("[TB] FAIL %s motor_en: got %b expected %b at %0t", tag, motor_en, m_exp_en, $time);
    end
    if (lost !== (m_state == STOP)) begin
      miss_cnt++;
      $display("[TB] FAIL %s lost: got %b expected %b at %0t", tag, lost, (m_state == STOP), $time);
    end
  endtask

  task automatic checkValue(string name, int got, int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(logic [2:0] i, logic p, logic r);
    induct = i;
    proxim = p;
    red    = r;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("cycle");
    end
  endtask

  typedef struct {
    logic [2:0] ind;
    logic       prox;
    logic       rd;
    int         hold;
    state_e     st;
    logic [3:0] mi;
    logic       lst;
  } vec_t;

  vec_t tbl [12];
  int   n;
  int   ones;
  int   uneven;
  logic [2:0] r_ind;
  logic       r_prox;
  logic       r_red;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Bit 0 is the leftmost sensor, so 3'b001 asks for a left turn.
    tbl[0]  = '{3'b010, 1'b0, 1'b0, 12, FOLLOW, 4'b0101, 1'b0};
    tbl[1]  = '{3'b001, 1'b0, 1'b0, 10, TURN_L, 4'b1010, 1'b0};
    tbl[2]  = '{3'b111, 1'b0, 1'b0, 10, TURN_L, 4'b1010, 1'b0};
    tbl[3]  = '{3'b100, 1'b0, 1'b0, 10, TURN_R, 4'b0110, 1'b0};
    tbl[4]  = '{3'b000, 1'b0, 1'b0, 10, SEARCH, 4'b0110, 1'b0};
    tbl[5]  = '{3'b000, 1'b0, 1'b0, 20, STOP,   4'b0000, 1'b1};
    tbl[6]  = '{3'b010, 1'b0, 1'b1, 10, IDLE,   4'b0000, 1'b0};
    tbl[7]  = '{3'b010, 1'b0, 1'b0, 10, FOLLOW, 4'b0101, 1'b0};
    tbl[8]  = '{3'b010, 1'b1, 1'b0, 10, OBST,   4'b0000, 1'b0};
    tbl[9]  = '{3'b010, 1'b0, 1'b0, 16, FOLLOW, 4'b0101, 1'b0};
    tbl[10] = '{3'b010, 1'b1, 1'b1, 10, IDLE,   4'b0000, 1'b0};
    tbl[11] = '{3'b010, 1'b0, 1'b0, 10, FOLLOW, 4'b0101, 1'b0};

    modelReset();
    applyStimulus(3'b010, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].ind, tbl[i].prox, tbl[i].rd);
      tick(tbl[i].hold);
      checkValue($sformatf("tbl%0d state", i), int'(state_o), int'(tbl[i].st));
      checkValue($sformatf("tbl%0d motor_in", i), int'(motor_in), int'(tbl[i].mi));
      checkValue($sformatf("tbl%0d lost", i), int'(lost), int'(tbl[i].lst));
    end

    applyStimulus(3'b001, 1'b0, 1'b0);
    n = 0;
    do begin tick(1); n++; end while (state_o != 3'(TURN_L) && n < 20);
    checkValue("turn latency", n, 2 + DEB_CYC + 1);
    checkValue("turn motor_in", int'(motor_in), 4'b1010);

    tick(3);
    applyStimulus(3'b100, 1'b0, 1'b0);
    tick(3);
    applyStimulus(3'b001, 1'b0, 1'b0);
    tick(10);
    checkValue("glitch state", int'(state_o), int'(TURN_L));
    checkValue("glitch motor_in", int'(motor_in), 4'b1010);

    applyStimulus(3'b010, 1'b0, 1'b0);
    tick(10);
    duty_fwd = 8'h80;
    tick(2);
    ones = 0; uneven = 0;
    for (int c = 0; c < 256; c++) begin
      tick(1);
      if (motor_en == 2'b11) ones++;
      if (motor_en[0] != motor_en[1]) uneven++;
    end
    checkValue("pwm half duty ones", ones, 128);
    checkValue("pwm sides equal", uneven, 0);
    duty_fwd = 8'h00;
    tick(2);
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(1); if (motor_en != 2'b00) ones++; end
    checkValue("pwm zero duty", ones, 0);
    duty_fwd = 8'hFF;
    tick(2);
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(1); if (motor_en == 2'b11) ones++; end
    checkValue("pwm full duty", ones, 256);
    duty_fwd = 8'h80;

    applyStimulus(3'b010, 1'b1, 1'b0);
    tick(10);
    checkValue("obst entry", int'(state_o), int'(OBST));
    checkValue("obst motor_en", int'(motor_en), 0);
    applyStimulus(3'b010, 1'b0, 1'b0);
    tick(5);
    applyStimulus(3'b010, 1'b1, 1'b0);
    tick(8);
    checkValue("obst restart hold", int'(state_o), int'(OBST));
    applyStimulus(3'b010, 1'b0, 1'b0);
    n = 0;
    do begin tick(1); n++; end while (state_o != 3'(FOLLOW) && n < 40);
    checkValue("obst resume latency", n, 2 + DEB_CYC + RESUME_CYC);

    applyStimulus(3'b100, 1'b0, 1'b0);
    tick(10);
    checkValue("pre-reset state", int'(state_o), int'(TURN_R));
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async reset");
    applyStimulus(3'b010, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(12);
    checkValue("post-reset state", int'(state_o), int'(FOLLOW));

    for (int s = 0; s < 300; s++) begin
      r_ind  = 3'($urandom_range(0, 7));
      r_prox = ($urandom_range(0, 9) == 0);
      r_red  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: duty_fwd = 8'h00;
          1: duty_fwd = 8'hFF;
          default: duty_fwd = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 7) == 0) duty_turn = 8'($urandom_range(0, 255));
      applyStimulus(r_ind, r_prox, r_red);
      tick($urandom_range(1, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
